// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin arbiter sharing one BCD-to-binary converter among NUM_REQ requesters
// Ports:
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   req_i, bcd_i           per-requester level request and BCD operand (requester k at [k*BCD_W +: BCD_W])
//   done_o, result_o       one-cycle completion pulse to the owner, registered binary result
//   grant_o, busy_o        one-hot converter owner, high outside IDLE
//   err_o                  one-cycle watchdog abort pulse to the owner
//   conv_*                 handshake with the shared converter
// Optional feature: define ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYC cycles).
module bcd_convert_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BCD_W       = 13,
  parameter int BIN_W       = 32,
  parameter int TIMEOUT_CYC = 255
)(
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*BCD_W-1:0] bcd_i,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [BIN_W-1:0]         result_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic                     conv_start_o,
  output logic [BCD_W-1:0]         conv_bcd_o,
  input  logic                     conv_ready_i,
  input  logic                     conv_done_i,
  input  logic [BIN_W-1:0]         conv_binary_i
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] ptr, owner, win, idx, owner_inc;
  logic any_req, take, abort;
  // scan downward so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    win = '0;
    idx = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req_i[idx]) begin
        win = idx;
        any_req = 1'b1;
      end
    end
  end
  assign take = state == IDLE && any_req && conv_ready_i;
  assign owner_inc = PW'((int'(owner) + 1) % NUM_REQ);
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = take ? START : IDLE;
      START: state_nxt = WAIT;
      WAIT:  state_nxt = conv_done_i ? RESP : abort ? IDLE : WAIT;
      RESP:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state <= IDLE;
    else state <= state_nxt;
  // owner is only meaningful outside IDLE, so grant and done derive from it and the state
  assign busy_o = state != IDLE;
  assign conv_start_o = state == START;
  assign grant_o = busy_o ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner : '0;
  assign done_o = state == RESP ? grant_o : '0;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      ptr <= '0;
      owner <= '0;
      conv_bcd_o <= '0;
      result_o <= '0;
    end else begin
      if (take) begin
        owner <= win;
        conv_bcd_o <= bcd_i[int'(win)*BCD_W +: BCD_W];
      end
      if (state == WAIT && conv_done_i) result_o <= conv_binary_i;
      if (state == RESP || abort) ptr <= owner_inc;
    end
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wdog;
  // a done arriving on the final watchdog cycle still wins over the abort
  assign abort = state == WAIT && !conv_done_i && wdog == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      wdog <= '0;
      err_o <= '0;
    end else begin
      wdog <= (state == WAIT && !conv_done_i && !abort) ? wdog + TW'(1) : '0;
      err_o <= abort ? grant_o : '0;
    end
`else
  assign abort = 1'b0;
  assign err_o = '0;
`endif
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: randomized self-checking bench with a behavioural converter and arbitration model
module tb_bcd_convert_arbiter;
  localparam int N = 4, BW = 13, RW = 32;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req = '0;
  logic [N*BW-1:0] bcd = '0;
  logic [N-1:0] done, grant, err;
  logic [RW-1:0] result, conv_bin, cbin, cval, stray_bin = '0;
  logic busy, conv_start, conv_ready, conv_done, cbusy, cdone;
  logic [BW-1:0] conv_bcd;
  logic ready_force = 1, done_en = 1, stray = 0;
  logic [BW-1:0] opnd [N];
  int cnt, lat = 1, mptr = 0, n_checks = 0, n_fail = 0, n_start = 0;

  bcd_convert_arbiter #(.NUM_REQ(N), .BCD_W(BW), .BIN_W(RW), .TIMEOUT_CYC(10)) dut (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req), .bcd_i(bcd), .done_o(done), .result_o(result),
    .grant_o(grant), .busy_o(busy), .err_o(err), .conv_start_o(conv_start), .conv_bcd_o(conv_bcd),
    .conv_ready_i(conv_ready), .conv_done_i(conv_done), .conv_binary_i(conv_bin));

  always #5 clk = ~clk;

  function automatic int bcd2bin(input logic [BW-1:0] v);
    int r, m;
    r = 0;
    m = 1;
    for (int i = 0; i < BW; i += 4) begin
      r += int'((v >> i) & 13'hF) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] mask, input int p);
    for (int i = 0; i < N; i++)
      if (mask[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  function automatic logic [BW-1:0] rand_bcd();
    return {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  // converter model: done arrives lat+1 cycles after the cycle following the start strobe
  assign conv_ready = !cbusy && ready_force;
  assign conv_done = cdone | stray;
  assign conv_bin = stray ? stray_bin : cbin;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cbusy <= 0; cdone <= 0; cbin <= '0; cval <= '0; cnt <= 0;
    end else begin
      cdone <= 0;
      if (cbusy) begin
        if (cnt == 0) begin
          cdone <= 1; cbin <= cval; cbusy <= 0;
        end else cnt <= cnt - 1;
      end else if (conv_start && done_en) begin
        cbusy <= 1; cnt <= lat; cval <= RW'(bcd2bin(conv_bcd));
      end
    end

  always @(negedge clk) if (conv_start) n_start++;

  task automatic set_req(input int k, input logic [BW-1:0] v);
    req[k] = 1'b1;
    bcd[k*BW +: BW] = v;
    opnd[k] = v;
  endtask

  task automatic serve(input string nm, input int drop_at, input bit keep, output int own);
    int t;
    logic [BW-1:0] op;
    own = pick(req, mptr);
    op = opnd[own];
    t = 0;
    while (grant === '0 && t < 100) begin @(negedge clk); t++; end
    n_checks++;
    if (grant !== 4'(1 << own) || conv_start !== 1'b1) begin
      n_fail++; $display("FAIL %s_grant: grant=%b start=%b, expected grant=%b start=1", nm, grant, conv_start, 4'(1 << own));
    end
    t = 0;
    while (done === '0 && t < 200) begin
      @(negedge clk); t++;
      if (t == drop_at) begin req[own] = 1'b0; bcd[own*BW +: BW] = ~op; end
    end
    n_checks++;
    if (done !== 4'(1 << own) || result !== RW'(bcd2bin(op))) begin
      n_fail++; $display("FAIL %s_done: done=%b result=%0d, expected done=%b result=%0d", nm, done, result, 4'(1 << own), bcd2bin(op));
    end
    n_checks++;
    if (t !== 3 + lat) begin
      n_fail++; $display("FAIL %s_latency: %0d cycles, expected %0d", nm, t, 3 + lat);
    end
    if (!keep) req[own] = 1'b0;
    mptr = (own + 1) % N;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grant !== '0 || done !== '0) begin
      n_fail++; $display("FAIL %s_idle_gap: busy=%b grant=%b done=%b, expected all zero", nm, busy, grant, done);
    end
  endtask

  task automatic test_reset();
    set_req(0, 13'h005);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({grant, done, err, busy, conv_start, conv_bcd, result} !== '0) begin
        n_fail++; $display("FAIL reset_values: grant=%b done=%b err=%b busy=%b start=%b bcd=%h result=%0d, expected zero",
                           grant, done, err, busy, conv_start, conv_bcd, result);
      end
    end
    req = '0;
    rst_n = 1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int own, s0;
    lat = 2;
    s0 = n_start;
    set_req(2, 13'h042);
    serve("single", -1, 0, own);
    n_checks++;
    if (n_start - s0 !== 1 || result !== 32'd42) begin
      n_fail++; $display("FAIL single_start_result: starts=%0d result=%0d, expected 1 and 42", n_start - s0, result);
    end
  endtask

  task automatic test_round_robin();
    int own;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst_n = 0;
    set_req(0, 13'h001); set_req(1, 13'h010); set_req(2, 13'h099); set_req(3, 13'h123);
    @(negedge clk);
    rst_n = 1;
    mptr = 0;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      serve("round_robin", -1, 1, own);
      n_checks++;
      if (own !== exp_order[i]) begin
        n_fail++; $display("FAIL rr_order: step %0d owner=%0d, expected %0d", i, own, exp_order[i]);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    int own;
    set_req(1, rand_bcd());
    lat = 3;
    serve("drop", 2, 0, own);
  endtask

  task automatic test_ready_low();
    int own;
    ready_force = 0;
    set_req(0, rand_bcd());
    set_req(3, rand_bcd());
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (grant !== '0 || conv_start !== 1'b0) begin
        n_fail++; $display("FAIL ready_low_hold: grant=%b start=%b, expected 0 0", grant, conv_start);
      end
    end
    ready_force = 1;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'(1 << pick(req, mptr))) begin
      n_fail++; $display("FAIL ready_low_release: grant=%b, expected %b", grant, 4'(1 << pick(req, mptr)));
    end
    lat = 0;
    serve("ready_low_a", -1, 0, own);
    serve("ready_low_b", -1, 0, own);
  endtask

  task automatic test_stray_done();
    logic [RW-1:0] r0;
    r0 = result;
    stray_bin = $urandom;
    stray = 1;
    @(negedge clk);
    stray = 0;
    @(negedge clk);
    n_checks++;
    if (result !== r0 || busy !== 1'b0 || done !== '0) begin
      n_fail++; $display("FAIL stray_done: result=%0d busy=%b done=%b, expected result=%0d busy=0 done=0", result, busy, done, r0);
    end
  endtask

  task automatic test_reset_mid();
    int own, t;
    lat = 20;
    set_req(3, rand_bcd());
    t = 0;
    while (grant === '0 && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({grant, done, err, busy, conv_start, conv_bcd, result} !== '0) begin
      n_fail++; $display("FAIL reset_mid: grant=%b done=%b err=%b busy=%b start=%b bcd=%h result=%0d, expected zero",
                         grant, done, err, busy, conv_start, conv_bcd, result);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1;
    mptr = 0;
    lat = 1;
    set_req(2, rand_bcd());
    serve("after_reset", -1, 0, own);
  endtask

  task automatic test_random();
    int own;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++)
        if (!req[k] && $urandom_range(0, 1)) set_req(k, rand_bcd());
      if (req == '0) set_req($urandom_range(0, N - 1), rand_bcd());
      lat = $urandom_range(0, 3);
      serve("random", $urandom_range(0, 3) == 0 ? 2 : -1, 0, own);
    end
    req = '0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int own, t;
    bit saw_done;
    logic [RW-1:0] r0;
    done_en = 0;
    r0 = result;
    set_req(1, rand_bcd());
    set_req(3, rand_bcd());
    own = pick(req, mptr);
    t = 0;
    while (grant === '0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    saw_done = 0;
    while (err === '0 && t < 50) begin
      @(negedge clk); t++;
      if (done !== '0) saw_done = 1;
    end
    n_checks++;
    if (err !== 4'(1 << own) || t !== 11 || saw_done || result !== r0) begin
      n_fail++; $display("FAIL timeout_abort: err=%b after %0d cycles done_seen=%0d result=%0d, expected err=%b after 11, no done, result=%0d",
                         err, t, saw_done, result, 4'(1 << own), r0);
    end
    req[own] = 1'b0;
    mptr = (own + 1) % N;
    done_en = 1;
    lat = 1;
    serve("after_timeout", -1, 0, own);
  endtask
`else
  task automatic test_timeout();
    int t;
    done_en = 0;
    set_req(0, rand_bcd());
    t = 0;
    while (grant === '0 && t < 100) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || err !== '0 || grant !== 4'b0001) begin
      n_fail++; $display("FAIL wait_forever: busy=%b err=%b grant=%b, expected 1 0000 0001", busy, err, grant);
    end
    rst_n = 0;
    req = '0;
    done_en = 1;
    @(negedge clk);
    rst_n = 1;
    mptr = 0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_ready_low();
    test_stray_done();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks done", n_checks);
    $fatal(1);
  end
endmodule

// File: doc/bcd_convert_arbiter.md
BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one BCD-to-binary converter (2..8).
REQ-002 Parameter BCD_W, default 13: BCD operand width per requester.
REQ-003 Parameter BIN_W, default 32: converter result width.
REQ-004 Parameter TIMEOUT_CYC, default 255: watchdog limit in cycles; used only with ARB_TIMEOUT_EN.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_ni  input  1  asynchronous, active-low reset.
REQ-007 req_i  input  NUM_REQ  level request per requester; held high until that requester's done pulse.
REQ-008 bcd_i  input  NUM_REQ*BCD_W  operand of requester k in bits [k*BCD_W +: BCD_W].
REQ-009 done_o  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-010 result_o  output  BIN_W  registered binary result, valid in the done_o cycle and held until the next completion.
REQ-011 grant_o  output  NUM_REQ  one-hot owner of the converter; all-zero when idle.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 err_o  output  NUM_REQ  one-cycle timeout pulse to the owner; constant zero without ARB_TIMEOUT_EN.
REQ-014 conv_start_o  output  1  converter start strobe.
REQ-015 conv_bcd_o  output  BCD_W  operand to the converter, registered.
REQ-016 conv_ready_i  input  1  converter idle and able to accept start.
REQ-017 conv_done_i  input  1  converter completion pulse.
REQ-018 conv_binary_i  input  BIN_W  converter result, sampled when conv_done_i is high.

Function
REQ-019 FSM states: IDLE, START, WAIT, RESP.
REQ-020 IDLE: when any req_i bit is high and conv_ready_i is high, the arbiter selects a winner round-robin starting at pointer ptr, latches the winner's bcd_i into conv_bcd_o, sets grant_o, and enters START.
REQ-021 START: conv_start_o is high for exactly one cycle; the next state is WAIT.
REQ-022 WAIT: when conv_done_i is high, conv_binary_i is registered into result_o and the FSM enters RESP; conv_start_o stays low.
REQ-023 RESP: done_o[owner] is high for one cycle; ptr becomes (owner+1) mod NUM_REQ; grant_o clears; the next state is IDLE.
REQ-024 Latency from a request seen in IDLE to done_o is 3 cycles plus the converter latency. IDLE is held for at least one cycle between grants.
REQ-025 Fairness: a requester that holds req_i is granted within NUM_REQ grants.
REQ-026 A req_i deassertion after grant does not abort the conversion; the done pulse and result are still issued.
REQ-027 bcd_i changes after the IDLE capture cycle have no effect on the running conversion.
REQ-028 conv_done_i outside WAIT is ignored.
REQ-029 When conv_ready_i is low in IDLE, no grant is made and the FSM stays in IDLE.
REQ-030 A single requester requesting continuously is re-granted back-to-back; ptr wrap from NUM_REQ-1 goes to 0.

Reset
REQ-031 When reset_ni is low, the FSM goes to IDLE immediately and asynchronously, including mid-conversion.
REQ-032 Reset values: ptr=0, grant_o=0, done_o=0, err_o=0, busy_o=0, conv_start_o=0, conv_bcd_o=0, result_o=0, watchdog=0.
REQ-033 After reset deassertion, the first arbitration occurs no earlier than the first rising edge with reset_ni high.

Configuration
REQ-034 Macro ARB_TIMEOUT_EN defined: a WAIT-state counter aborts after TIMEOUT_CYC cycles without conv_done_i. On abort, err_o[owner] pulses for one cycle, no done_o pulse is issued, result_o is unchanged, ptr advances, and the FSM returns to IDLE.
REQ-035 Macro ARB_TIMEOUT_EN undefined: no counter logic exists, WAIT lasts indefinitely, and err_o is tied to zero.

Verification
REQ-036 Requester 2 alone, bcd 13'h042, real converter attached -> grant_o=4'b0100, a single conv_start_o pulse, done_o=4'b0100 with result_o=42.
REQ-037 All four requesters high from reset, distinct operands 0x001/0x010/0x099/0x123 -> grant order 0,1,2,3,0 and each result_o matches its operand (1/10/99/123).
REQ-038 Requester 1 drops req_i two cycles after grant -> done_o[1] still pulses with the correct result.
REQ-039 reset_ni asserted during WAIT -> all outputs at reset values immediately; a fresh request afterward is serviced normally.
REQ-040 ARB_TIMEOUT_EN with TIMEOUT_CYC=10 and conv_done_i tied low -> err_o[owner] pulses after 10 WAIT cycles, no done_o, and the next requester is granted.
REQ-041 conv_ready_i held low for 5 cycles with requests pending -> no grant and no start; the grant is made in the first IDLE cycle with conv_ready_i high.
